// File: rtl/hb_chain_ctrl_if.sv
// Sample-path bundle between the halfband chain controller and the chain/source.
// master = controller side, slave = source/stage side.
interface hb_chain_ctrl_if;
  logic [15:0] src_data;
  logic        src_valid;
  logic        hb1_v, hb2_v, hb3_v;
  logic [15:0] hb1_y, hb2_y, hb3_y;
  logic        hb_clr_n;
  logic [2:0]  hb_x_valid;
  logic [15:0] out_data;
  logic        out_valid;

  modport master (
    input  src_data, src_valid, hb1_v, hb2_v, hb3_v, hb1_y, hb2_y, hb3_y,
    output hb_clr_n, hb_x_valid, out_data, out_valid
  );
  modport slave (
    output src_data, src_valid, hb1_v, hb2_v, hb3_v, hb1_y, hb2_y, hb3_y,
    input  hb_clr_n, hb_x_valid, out_data, out_valid
  );
endinterface

// File: rtl/hb_chain_ctrl.sv
// Sequencer for a 3-stage halfband decimator cascade: flush, warm-up discard, output mux.
// Optional statistics counters are enabled by defining HBCTRL_STATS_EN.
module hb_chain_ctrl #(
  parameter int FLUSH_CYC  = 4,
  parameter int WARMUP_OUT = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hb_chain_ctrl_if.master      bus,
  input  logic                 enable_i,
  input  logic [1:0]           cfg_stages_i,
  input  logic                 cfg_load_i,
  output logic [1:0]           state_o,
  output logic                 busy_o,
  output logic [7:0]           stat_drop_o,
  output logic [31:0]          stat_out_o
);
  localparam int FW = $clog2(FLUSH_CYC + 1);
  localparam int WW = $clog2(WARMUP_OUT + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, FLUSH = 2'd1, WARMUP = 2'd2, RUN = 2'd3} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cfg_q, cfg_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            clr_n_q, clr_n_d;
  logic [15:0]     od_q, od_d;
  logic            ov_q, ov_d;
  logic            sel_v;
  logic [15:0]     sel_y;
  logic            active;
  logic [2:0]      gate;

  always_comb begin
    sel_v = bus.src_valid;
    sel_y = bus.src_data;
    case (cfg_q)
      2'd1: begin sel_v = bus.hb1_v; sel_y = bus.hb1_y; end
      2'd2: begin sel_v = bus.hb2_v; sel_y = bus.hb2_y; end
      2'd3: begin sel_v = bus.hb3_v; sel_y = bus.hb3_y; end
      default: ;
    endcase
  end

  // Stage i is fed only when it is part of the configured chain and the chain is live.
  assign active = (state_q == WARMUP) || (state_q == RUN);
  always_comb begin
    gate = '0;
    for (int i = 0; i < 3; i++) gate[i] = active && (2'(i) < cfg_q);
  end

  assign bus.hb_x_valid = {bus.hb2_v & gate[2], bus.hb1_v & gate[1], bus.src_valid & gate[0]};

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    fcnt_d  = fcnt_q;
    wcnt_d  = wcnt_q;
    ov_d    = 1'b0;
    od_d    = od_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE || cfg_load_i) begin
      state_d = FLUSH;
      cfg_d   = cfg_stages_i;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        FLUSH: begin
          if (fcnt_q == FW'(FLUSH_CYC - 1)) begin
            state_d = (cfg_q != 2'd0 && WARMUP_OUT != 0) ? WARMUP : RUN;
            wcnt_d  = '0;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
        WARMUP: begin
          if (sel_v) begin
            if (wcnt_q == WW'(WARMUP_OUT - 1)) state_d = RUN;
            else                               wcnt_d  = wcnt_q + 1'b1;
          end
        end
        RUN: begin
          if (sel_v) begin
            ov_d = 1'b1;
            od_d = sel_y;
          end
        end
        default: ;
      endcase
    end
    // Stage reset follows the next state so it releases on the edge leaving FLUSH.
    clr_n_d = (state_d == WARMUP) || (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      fcnt_q  <= '0;
      wcnt_q  <= '0;
      clr_n_q <= 1'b0;
      od_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      fcnt_q  <= fcnt_d;
      wcnt_q  <= wcnt_d;
      clr_n_q <= clr_n_d;
      od_q    <= od_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.hb_clr_n  = clr_n_q;
  assign bus.out_data  = od_q;
  assign bus.out_valid = ov_q;
  assign state_o       = state_q;
  assign busy_o        = (state_q == FLUSH) || (state_q == WARMUP);

`ifdef HBCTRL_STATS_EN
  logic [7:0]  drop_q;
  logic [31:0] outs_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
      outs_q <= '0;
    end else begin
      if (state_q == FLUSH && bus.src_valid && drop_q != 8'hff) drop_q <= drop_q + 1'b1;
      if (ov_q) outs_q <= outs_q + 1'b1;
    end
  end
  assign stat_drop_o = drop_q;
  assign stat_out_o  = outs_q;
`else
  assign stat_drop_o = '0;
  assign stat_out_o  = '0;
`endif
endmodule

// File: tb/tb_hb_chain_ctrl.sv
// Directed bench for hb_chain_ctrl: flush/warm-up sequencing, gating, output mux, stats.
module tb_hb_chain_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  cfg_stages;
  logic        cfg_load;
  logic [1:0]  state;
  logic        busy;
  logic [7:0]  stat_drop;
  logic [31:0] stat_out;
  int          n_chk = 0;
  int          n_err = 0;
  int          exp_outs = 0;
  int          nfl;

  hb_chain_ctrl_if bus();

  hb_chain_ctrl #(.FLUSH_CYC(4), .WARMUP_OUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master),
    .enable_i(enable), .cfg_stages_i(cfg_stages), .cfg_load_i(cfg_load),
    .state_o(state), .busy_o(busy), .stat_drop_o(stat_drop), .stat_out_o(stat_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic all_v(input logic v);
    bus.src_valid = v; bus.hb1_v = v; bus.hb2_v = v; bus.hb3_v = v;
  endtask

  // n discarded valids on stage s while in WARMUP; no output may appear
  task automatic warm(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      case (s)
        1: begin bus.hb1_v = 1'b1; bus.hb1_y = 16'(k + 16'h100); end
        2: begin bus.hb2_v = 1'b1; bus.hb2_y = 16'(k + 16'h200); end
        default: begin bus.hb3_v = 1'b1; bus.hb3_y = 16'(k + 16'h300); end
      endcase
      tick();
      all_v(1'b0);
      chk("warm_no_out", bus.out_valid, 1'b0);
    end
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; cfg_stages = 2'd0; cfg_load = 1'b0;
    all_v(1'b0);
    bus.src_data = '0; bus.hb1_y = '0; bus.hb2_y = '0; bus.hb3_y = '0;
    #12;
    chk("rst_state", state, 2'd0);
    chk("rst_clr_n", bus.hb_clr_n, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stat_drop", stat_drop, 8'h0);
    chk("rst_stat_out", stat_out, 32'h0);
    tick();
    reset_n = 1'b1;

    // cfg=3: flush 4 cycles, 4 discards, 5th hb3 sample goes out
    enable = 1'b1; cfg_stages = 2'd3;
    tick();
    chk("t1_flush", state, 2'd1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_clr_low0", bus.hb_clr_n, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_flush_hold", state, 2'd1);
      chk("t1_clr_low", bus.hb_clr_n, 1'b0);
    end
    tick();
    chk("t1_warmup", state, 2'd2);
    chk("t1_clr_high", bus.hb_clr_n, 1'b1);
    bus.src_valid = 1'b1; bus.hb1_v = 1'b1; bus.hb2_v = 1'b1; #1;
    chk("t1_gates", bus.hb_x_valid, 3'b111);
    all_v(1'b0);
    warm(3, 4);
    chk("t1_run", state, 2'd3);
    chk("t1_run_busy", busy, 1'b0);
    bus.hb3_v = 1'b1; bus.hb3_y = 16'h8123;
    tick();
    bus.hb3_v = 1'b0;
    chk("t1_out_valid", bus.out_valid, 1'b1);
    chk("t1_out_data", bus.out_data, 16'h8123);
    exp_outs++;
    tick();
    chk("t1_strobe", bus.out_valid, 1'b0);

    // bypass: no warm-up, src passes with 1-cycle latency, no stage fed
    cfg_stages = 2'd0; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t2_flush", state, 2'd1);
    chk("t2_clr_low", bus.hb_clr_n, 1'b0);
    repeat (3) tick();
    chk("t2_still_flush", state, 2'd1);
    tick();
    chk("t2_run", state, 2'd3);
    chk("t2_clr_high", bus.hb_clr_n, 1'b1);
    for (int k = 0; k < 6; k++) begin
      bus.src_valid = 1'b1; bus.src_data = 16'(k); #1;
      chk("t2_gates", bus.hb_x_valid, 3'b000);
      tick();
      chk("t2_ov", bus.out_valid, 1'b1);
      chk("t2_data", bus.out_data, 16'(k));
      exp_outs++;
    end
    bus.src_valid = 1'b0;
    tick();
    chk("t2_ov_end", bus.out_valid, 1'b0);

    // cfg=2 to RUN, then reload cfg=1 with a second pulse on flush cycle 2
    cfg_stages = 2'd2; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    repeat (4) tick();
    chk("t3_warmup2", state, 2'd2);
    warm(2, 4);
    chk("t3_run2", state, 2'd3);
    cfg_stages = 2'd1; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("t3_flush_c1", state, 2'd1);
    tick();
    chk("t3_flush_c2", state, 2'd1);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    nfl = 2;
    for (int g = 0; g < 20; g++) begin
      if (state == 2'd1 && bus.hb_clr_n == 1'b0) nfl++;
      else break;
      tick();
    end
    chk("t3_flush_len", nfl, 6);
    chk("t3_warmup1", state, 2'd2);
    chk("t3_clr_high", bus.hb_clr_n, 1'b1);
    all_v(1'b1); #1;
    chk("t3_gates", bus.hb_x_valid, 3'b001);
    all_v(1'b0);
    bus.hb2_v = 1'b1;
    tick();
    bus.hb2_v = 1'b0;
    chk("t3_unsel_ignored", state, 2'd2);
    warm(1, 4);
    chk("t3_run1", state, 2'd3);
    all_v(1'b1); bus.hb1_y = 16'h1234; bus.hb2_y = 16'h5555; bus.hb3_y = 16'h6666; #1;
    chk("t3_run_gates", bus.hb_x_valid, 3'b001);
    tick();
    all_v(1'b0);
    chk("t3_ov", bus.out_valid, 1'b1);
    chk("t3_data", bus.out_data, 16'h1234);
    exp_outs++;

    // selected valid coincident with cfg_load is not output
    bus.hb1_v = 1'b1; bus.hb1_y = 16'hbeef; cfg_stages = 2'd0; cfg_load = 1'b1;
    tick();
    bus.hb1_v = 1'b0; cfg_load = 1'b0;
    chk("t4_ov_drop", bus.out_valid, 1'b0);
    chk("t4_flush", state, 2'd1);
    repeat (4) tick();
    chk("t4_run", state, 2'd3);

    // enable drop together with a selected valid
    bus.src_valid = 1'b1; bus.src_data = 16'd77; enable = 1'b0;
    tick();
    chk("t5_ov", bus.out_valid, 1'b0);
    chk("t5_idle", state, 2'd0);
    chk("t5_clr_low", bus.hb_clr_n, 1'b0);
    chk("t5_busy", busy, 1'b0);
    all_v(1'b1); #1;
    chk("t5_gates", bus.hb_x_valid, 3'b000);
    all_v(1'b0);
    chk("t5_no_drops", stat_drop, 8'h0);

    // 300 src samples during a flush held open by repeated cfg_load
    enable = 1'b1; cfg_load = 1'b1; bus.src_valid = 1'b1; bus.hb1_v = 1'b1;
    repeat (301) tick();
    chk("t6_flush_gates", bus.hb_x_valid, 3'b000);
    cfg_load = 1'b0; all_v(1'b0);
    chk("t6_flush", state, 2'd1);
    chk("t6_busy", busy, 1'b1);
`ifdef HBCTRL_STATS_EN
    chk("t6_stat_drop", stat_drop, 8'd255);
    chk("t6_stat_out", stat_out, 32'(exp_outs));
`else
    chk("t6_stat_drop", stat_drop, 8'd0);
    chk("t6_stat_out", stat_out, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
